// File: rtl/uart_transmitter.sv
// UART transmitter: frames one parallel word per request (start, data LSB first,
// optional parity, stop bits), paced by the oversampling baud tick shared with the receiver.
module uart_transmitter #(
    parameter int NDATA_BITS   = 8,
    parameter int NSTOP_BITS   = 1,
    parameter int OVERSAMPLING = 16,
    parameter int PARITY       = 0
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_baud,
    input  logic                  i_tx_start,
    input  logic [NDATA_BITS-1:0] i_data,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_tx_done
);
    localparam int TICK_W = $clog2(OVERSAMPLING);
    localparam int BIT_W  = $clog2(NDATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NDATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(NSTOP_BITS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] PARITY_S = 3'd3;
    localparam logic [2:0] STOP     = 3'd4;

    logic [2:0]            state, state_n;
    logic [TICK_W-1:0]     tick_ctr, tick_n;
    logic [BIT_W-1:0]      bit_ctr, bit_n;
    logic                  stop_ctr, stop_n;
    logic [NDATA_BITS-1:0] shift, shift_n;
    logic                  parity_bit, parity_n;
    logic                  tx_n;
    logic                  done_n;
    logic                  bit_end;

    assign bit_end = i_baud && (tick_ctr == TICK_LAST);

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_n  = state;
        tick_n   = tick_ctr;
        bit_n    = bit_ctr;
        stop_n   = stop_ctr;
        shift_n  = shift;
        parity_n = parity_bit;
        done_n   = 1'b0;

        if (state == IDLE) begin
            if (i_tx_start) begin
                shift_n  = i_data;
                parity_n = (PARITY == 1) ? ~^i_data : ^i_data;
                tick_n   = '0;
                state_n  = START;
            end
        end else if (i_baud) begin
            if (!bit_end) begin
                tick_n = tick_ctr + TICK_W'(1);
            end else begin
                tick_n = '0;
                case (state)
                    START: begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                    DATA: begin
                        shift_n = shift >> 1;
                        if (bit_ctr == BIT_LAST) begin
                            state_n = (PARITY != 0) ? PARITY_S : STOP;
                            stop_n  = 1'b0;
                        end else begin
                            bit_n = bit_ctr + BIT_W'(1);
                        end
                    end
                    PARITY_S: begin
                        state_n = STOP;
                        stop_n  = 1'b0;
                    end
                    STOP: begin
                        if (stop_ctr == STOP_LAST) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            stop_n = stop_ctr + 1'b1;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        case (state_n)
            START:    tx_n = 1'b0;
            DATA:     tx_n = shift_n[0];
            PARITY_S: tx_n = parity_n;
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            tick_ctr   <= '0;
            bit_ctr    <= '0;
            stop_ctr   <= 1'b0;
            shift      <= '0;
            parity_bit <= 1'b0;
            o_tx       <= 1'b1;
            o_busy     <= 1'b0;
            o_tx_done  <= 1'b0;
        end else begin
            state      <= state_n;
            tick_ctr   <= tick_n;
            bit_ctr    <= bit_n;
            stop_ctr   <= stop_n;
            shift      <= shift_n;
            parity_bit <= parity_n;
            o_tx       <= tx_n;
            o_busy     <= (state_n != IDLE);
            o_tx_done  <= done_n;
        end
    end
endmodule
